voice_allocator: RTL

Polyphonic voice allocator for the SaSS synthesizer. It sits between the debounced piano-key bank and a fixed pool of oscillator voices. It scans the keys one per clock and assigns each new press to a free voice, or steals the oldest voice when the pool is full. It frees voices on key release and emits a one-cycle strobe for every assignment so the voice datapath can retrigger its envelope.

---
 rtl/sass_pkg.sv | 11 +
 rtl/voice_select.sv | 40 ++++
 rtl/voice_allocator.sv | 103 ++++++++++
 3 files changed

// File: rtl/sass_pkg.sv
// Shared constants and index types for the SaSS key-to-voice datapath.
package sass_pkg;
  localparam int NUM_KEYS   = 15;
  localparam int NUM_VOICES = 4;
  localparam int KEY_W      = $clog2(NUM_KEYS);
  localparam int VOICE_W    = $clog2(NUM_VOICES);
  localparam int AGE_W      = 4;

  typedef logic [KEY_W-1:0]   key_idx_t;
  typedef logic [VOICE_W-1:0] voice_idx_t;
endpackage

// File: rtl/voice_select.sv
// Picks the voice for a new press: lowest free voice, else the oldest
// active voice with ties broken toward the lowest index.
module voice_select
  import sass_pkg::*;
#(
  parameter int NUM_VOICES = sass_pkg::NUM_VOICES,
  parameter int AGE_W      = sass_pkg::AGE_W
) (
  input  logic [NUM_VOICES-1:0]         active,
  input  logic [AGE_W-1:0]              age [NUM_VOICES],
  output logic [$clog2(NUM_VOICES)-1:0] target,
  output logic                          steal
);

  localparam int SEL_W = $clog2(NUM_VOICES);

  logic [AGE_W-1:0] best;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path leaves one unassigned and no latch is inferred.
    target = '0;
    best   = '0;
    steal  = &active;
    if (!steal) begin
      // Downward walk so the last hit is the lowest free index.
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
        if (!active[i]) target = SEL_W'(i);
      end
    end else begin
      best = age[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
        if (age[i] > best) begin
          best   = age[i];
          target = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Scans one key per clock, allocates presses to voices (stealing the oldest
// when full), frees voices on release and strobes every assignment.
module voice_allocator
  import sass_pkg::*;
#(
  parameter int NUM_KEYS   = sass_pkg::NUM_KEYS,
  parameter int NUM_VOICES = sass_pkg::NUM_VOICES,
  parameter int KEY_W      = $clog2(NUM_KEYS),
  parameter int AGE_W      = sass_pkg::AGE_W
) (
  input  logic                          hwclk,
  input  logic                          reset,
  input  logic [NUM_KEYS-1:0]           keys,
  input  logic                          scan_en,
  input  logic                          all_off,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic [NUM_VOICES*KEY_W-1:0]   voice_key,
  output logic                          alloc_strobe,
  output logic [$clog2(NUM_VOICES)-1:0] alloc_voice,
  output logic                          steal
);

  localparam int SEL_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [KEY_W-1:0] PTR_LAST = KEY_W'(NUM_KEYS - 1);

  logic [KEY_W-1:0]    ptr;
  logic [NUM_KEYS-1:0] prev;
  logic [KEY_W-1:0]    key_tab [NUM_VOICES];
  logic [AGE_W-1:0]    age     [NUM_VOICES];

  logic             cur;
  logic             press;
  logic             release_ev;
  logic [SEL_W-1:0] target;
  logic             steal_c;

  assign cur        = keys[ptr];
  assign press      = scan_en &  cur & ~prev[ptr];
  assign release_ev = scan_en & ~cur &  prev[ptr];

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_select (
    .active (voice_active),
    .age    (age),
    .target (target),
    .steal  (steal_c)
  );

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_key_out
    assign voice_key[v*KEY_W +: KEY_W] = key_tab[v];
  end

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      prev         <= '0;
      voice_active <= '0;
      alloc_strobe <= 1'b0;
      alloc_voice  <= '0;
      steal        <= 1'b0;
      // NOTE: the voice table is only a few registers and its outputs are visible, so it is reset like any other state.
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_tab[v] <= '0;
        age[v]     <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every voice sees the pre-edge table regardless of statement order.
      alloc_strobe <= 1'b0;
      steal        <= 1'b0;
      if (all_off) begin
        ptr          <= '0;
        prev         <= '0;
        voice_active <= '0;
        for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
      end else if (scan_en) begin
        prev[ptr] <= cur;
        ptr       <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        if (press) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (SEL_W'(v) == target) begin
              key_tab[v]      <= ptr;
              voice_active[v] <= 1'b1;
              age[v]          <= '0;
            end else if (voice_active[v] && age[v] != AGE_MAX) begin
              age[v] <= age[v] + 1'b1;
            end
          end
          alloc_strobe <= 1'b1;
          alloc_voice  <= target;
          steal        <= steal_c;
        end else if (release_ev) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_active[v] && key_tab[v] == ptr) voice_active[v] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
